// File: rtl/button_pkg.sv
// Shared types and constants for the push-button reader.
package button_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    // Depth of the input synchronizer chain.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM, press/release/long events.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 135,
    parameter int LONG_CYCLES     = 1000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o,
    output logic btn_long_o
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    // The edge that moves the FSM into a pending state has already seen one
    // stable sample, so the pending count stops one short of DEBOUNCE_CYCLES.
    // With DEBOUNCE_CYCLES == 1 that single sample is enough and the pending
    // states are skipped entirely.
    localparam bit                INSTANT  = (DEBOUNCE_CYCLES == 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic              IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act_s;
    btn_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [HOLD_W-1:0]      hold_q;
    logic                   long_done_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;

    // Synchronize the raw pin into the clk domain, idling at the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_PIN}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    // Normalize the synchronized pin so that 1 always means pressed.
    assign act_s = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

    // Debounce FSM with registered level and single-cycle event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (act_s) begin
                        cnt_q <= '0;
                        if (INSTANT) begin
                            state_q     <= PRESSED;
                            press_q     <= 1'b1;
                            level_q     <= 1'b1;
                            hold_q      <= '0;
                            long_done_q <= 1'b0;
                        end else begin
                            state_q <= PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!act_s) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= PRESSED;
                        cnt_q       <= '0;
                        press_q     <= 1'b1;
                        level_q     <= 1'b1;
                        hold_q      <= '0;
                        long_done_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!act_s) begin
                        cnt_q <= '0;
                        if (INSTANT) begin
                            state_q   <= RELEASED;
                            release_q <= 1'b1;
                            level_q   <= 1'b0;
                        end else begin
                            state_q <= RELEASE_PEND;
                        end
                    end else if (!long_done_q) begin
                        if (hold_q == HOLD_LAST) begin
                            long_q      <= 1'b1;
                            long_done_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q + HOLD_ONE;
                        end
                    end
                end
                RELEASE_PEND: begin
                    if (act_s) begin
                        // Release bounce: resume the press, hold count frozen meanwhile.
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= RELEASED;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q     <= RELEASED;
                    cnt_q       <= '0;
                    hold_q      <= '0;
                    long_done_q <= 1'b0;
                    level_q     <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;
    assign btn_long_o    = long_q;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: NUM_BTN independent button channels.
module button_reader
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 135,
    parameter int LONG_CYCLES     = 1000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .btn_i         (btn_in[g]),
            .btn_level_o   (btn_level[g]),
            .btn_press_o   (btn_press[g]),
            .btn_release_o (btn_release[g]),
            .btn_long_o    (btn_long[g])
        );
    end

endmodule
